conv_ctrl_param_gen: RTL

- Parametrised successor of the conv-layer control block for the CNN accelerator datapath.
- Sequences one convolution layer: issues a go/busy/done handshake, enables the address generators, and enables the M9K read ports.
- Drives the multiplier-accumulator sload/clear/enable controls and time-multiplexes INPUT_NUM_MEM feature memories onto IFMAP_PAR multiplier lanes in groups.
- Group count, lane count, per-group cycles, pipeline depth and output size are all generic.
- Adds stall support and an explicit drain phase.

---
 rtl/cnn_ctrl_pkg.sv | 34 +++
 rtl/ifmap_group_mux.sv | 39 +++
 rtl/conv_ctrl_param_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN conv-layer control slice.
// Holds the controller state encoding, a $clog2 helper that never returns
// a zero width, and the derivations of the layer geometry from the
// top-level parameters.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } ctrl_state_t;

    // Counter and select widths; a single-valued counter still needs one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int num_groups(input int input_num_mem, input int ifmap_par);
        return input_num_mem / ifmap_par;
    endfunction

    function automatic int num_one_pixel_cycle(input int inter, input int groups);
        return inter * groups;
    endfunction

    function automatic int total_pixels(input int out_feature_width, input int num_onemult);
        return out_feature_width * out_feature_width * num_onemult;
    endfunction

endpackage

// File: rtl/ifmap_group_mux.sv
// Selects one group of IFMAP_PAR feature memories onto the multiplier lanes.
// Ports:
//   feature_all  packed words of all memories, memory m at [m*DATA_WIDTH +: DATA_WIDTH]
//   group_sel    active memory group
//   valid        lanes carry data only while high, all-zero otherwise
//   lanes        lane k = memory group_sel*IFMAP_PAR + k
module ifmap_group_mux
    import cnn_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int INPUT_NUM_MEM = 6,
    parameter int IFMAP_PAR     = 3
) (
    input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]                         feature_all,
    input  logic [clog2_min1(num_groups(INPUT_NUM_MEM, IFMAP_PAR))-1:0] group_sel,
    input  logic                                                        valid,
    output logic [DATA_WIDTH*IFMAP_PAR-1:0]                             lanes
);

    localparam int NUM_GROUPS = num_groups(INPUT_NUM_MEM, IFMAP_PAR);
    localparam int GW         = clog2_min1(NUM_GROUPS);

    // Compare against every legal group instead of indexing, so an
    // out-of-range select simply yields zero lanes.
    always_comb begin
        lanes = '0;
        if (valid) begin
            for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                if (group_sel == GW'(g)) begin
                    for (int unsigned k = 0; k < IFMAP_PAR; k++) begin
                        lanes[k*DATA_WIDTH +: DATA_WIDTH] =
                            feature_all[(g*IFMAP_PAR + k)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_ctrl_param_gen.sv
// Conv-layer controller for the CNN accelerator datapath.
// Sequences one layer (IDLE -> PRIME -> RUN -> DRAIN -> DONE), enables the
// address generators and M9K read ports, drives the MAC sload/clear/enable
// controls and time-multiplexes the feature memories onto the multiplier
// lanes one group at a time.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   go                           start-layer pulse, only honoured in IDLE
//   enable                       run permission; low while active stalls everything
//   in_feature_q_a/b_all         read data of all feature memories (ports A/B)
//   busy                         layer in progress (PRIME through DONE)
//   enable_addrger/_weightaddrger address generator enables
//   in_feature_rden_a/b, weight_rden_a/b  M9K read enables
//   enable_mult, clear_mult, accum_sload  MAC controls
//   count_sload                  cycle index inside the current pixel
//   group_sel                    active memory group
//   pixel_count                  pixels completed in this layer
//   in_feature_q_a/b_mux_all     lane data of the active group
//   start                        first pixel of the layer has completed
//   conv_done                    one-cycle layer-complete pulse
module conv_ctrl_param_gen
    import cnn_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH                = 8,
    parameter int INPUT_NUM_MEM             = 6,
    parameter int IFMAP_PAR                 = 3,
    parameter int NUM_ONE_PIXEL_CYCLE_INTER = 4,
    parameter int OUT_FEATURE_WIDTH         = 2,
    parameter int NUM_ONEMULT               = 1,
    parameter int PIPE_DELAY                = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  go,
    input  logic                                  enable,
    input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]   in_feature_q_a_all,
    input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]   in_feature_q_b_all,
    output logic                                  busy,
    output logic                                  enable_addrger,
    output logic                                  enable_weightaddrger,
    output logic                                  in_feature_rden_a,
    output logic                                  in_feature_rden_b,
    output logic                                  weight_rden_a,
    output logic                                  weight_rden_b,
    output logic                                  enable_mult,
    output logic                                  clear_mult,
    output logic                                  accum_sload,
    output logic [clog2_min1(num_one_pixel_cycle(NUM_ONE_PIXEL_CYCLE_INTER,
                  num_groups(INPUT_NUM_MEM, IFMAP_PAR)))-1:0] count_sload,
    output logic [clog2_min1(num_groups(INPUT_NUM_MEM, IFMAP_PAR))-1:0] group_sel,
    output logic [clog2_min1(total_pixels(OUT_FEATURE_WIDTH, NUM_ONEMULT) + 1)-1:0] pixel_count,
    output logic [DATA_WIDTH*IFMAP_PAR-1:0]       in_feature_q_a_mux_all,
    output logic [DATA_WIDTH*IFMAP_PAR-1:0]       in_feature_q_b_mux_all,
    output logic                                  start,
    output logic                                  conv_done
);

    localparam int NUM_GROUPS          = num_groups(INPUT_NUM_MEM, IFMAP_PAR);
    localparam int NUM_ONE_PIXEL_CYCLE = num_one_pixel_cycle(NUM_ONE_PIXEL_CYCLE_INTER, NUM_GROUPS);
    localparam int TOTAL_PIXELS        = total_pixels(OUT_FEATURE_WIDTH, NUM_ONEMULT);

    localparam int CW  = clog2_min1(NUM_ONE_PIXEL_CYCLE);
    localparam int GW  = clog2_min1(NUM_GROUPS);
    localparam int PXW = clog2_min1(TOTAL_PIXELS + 1);
    localparam int SW  = clog2_min1(NUM_ONE_PIXEL_CYCLE_INTER);
    localparam int PHW = clog2_min1(PIPE_DELAY);

    localparam logic [CW-1:0]  COUNT_LAST = CW'(NUM_ONE_PIXEL_CYCLE - 1);
    localparam logic [GW-1:0]  GROUP_LAST = GW'(NUM_GROUPS - 1);
    localparam logic [PXW-1:0] PIXEL_LAST = PXW'(TOTAL_PIXELS - 1);
    localparam logic [SW-1:0]  SLOT_LAST  = SW'(NUM_ONE_PIXEL_CYCLE_INTER - 1);
    localparam logic [PHW-1:0] PHASE_LAST = PHW'(PIPE_DELAY - 1);

    if ((IFMAP_PAR < 1) || ((INPUT_NUM_MEM % IFMAP_PAR) != 0)) begin : g_bad_par
        $error("conv_ctrl_param_gen: IFMAP_PAR must divide INPUT_NUM_MEM");
    end
    if ((NUM_ONE_PIXEL_CYCLE_INTER < 1) || (PIPE_DELAY < 1)) begin : g_bad_len
        $error("conv_ctrl_param_gen: NUM_ONE_PIXEL_CYCLE_INTER and PIPE_DELAY must be >= 1");
    end

    ctrl_state_t    state;
    logic [PHW-1:0] phase_cnt;   // PRIME and DRAIN length counter
    logic [SW-1:0]  slot_q;      // cycle within the current group
    logic [GW-1:0]  group_q;
    logic [CW-1:0]  count_q;     // tracks group_q*INTER + slot_q
    logic [PXW-1:0] pixel_q;
    logic           busy_q;
    logic           clear_q;
    logic           done_q;
    logic           start_q;
    logic           rd_q;        // addrger/rden request before stall gating
    logic           mult_q;      // MAC enable request before stall gating
    logic           mux_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            slot_q    <= '0;
            group_q   <= '0;
            count_q   <= '0;
            pixel_q   <= '0;
            busy_q    <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            rd_q      <= 1'b0;
            mult_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_PRIME;
                        busy_q    <= 1'b1;
                        clear_q   <= 1'b1;
                        rd_q      <= 1'b1;
                        mult_q    <= 1'b0;
                        phase_cnt <= '0;
                        slot_q    <= '0;
                        group_q   <= '0;
                        count_q   <= '0;
                        pixel_q   <= '0;
                    end
                end

                S_PRIME: begin
                    clear_q <= 1'b0;
                    if (enable) begin
                        if (phase_cnt == PHASE_LAST) begin
                            state     <= S_RUN;
                            phase_cnt <= '0;
                            mult_q    <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (enable) begin
                        if (slot_q == SLOT_LAST) begin
                            slot_q  <= '0;
                            group_q <= (group_q == GROUP_LAST) ? '0 : group_q + 1'b1;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                        count_q <= (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;
                        if (count_q == COUNT_LAST) begin
                            pixel_q <= pixel_q + 1'b1;
                            if (pixel_q == '0) begin
                                start_q <= 1'b1;
                            end
                            if (pixel_q == PIXEL_LAST) begin
                                state     <= S_DRAIN;
                                rd_q      <= 1'b0;
                                phase_cnt <= '0;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (enable) begin
                        if (phase_cnt == PHASE_LAST) begin
                            state     <= S_DONE;
                            phase_cnt <= '0;
                            mult_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    start_q <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall gating sits after the registers so that enable low blanks the
    // read/MAC controls in the very cycle it is low, and they resume in the
    // cycle it returns; rd_q/mult_q are already 0 in IDLE and DONE.
    assign enable_addrger       = rd_q & enable;
    assign enable_weightaddrger = rd_q & enable;
    assign in_feature_rden_a    = rd_q & enable;
    assign in_feature_rden_b    = rd_q & enable;
    assign weight_rden_a        = rd_q & enable;
    assign weight_rden_b        = rd_q & enable;
    assign enable_mult          = mult_q & enable;
    assign accum_sload          = (state == S_RUN) && (count_q == '0) && enable;

    assign busy        = busy_q;
    assign clear_mult  = clear_q;
    assign conv_done   = done_q;
    assign start       = start_q;
    assign count_sload = count_q;
    assign group_sel   = group_q;
    assign pixel_count = pixel_q;

    assign mux_valid = (state == S_RUN) || (state == S_DRAIN);

    ifmap_group_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .INPUT_NUM_MEM(INPUT_NUM_MEM),
        .IFMAP_PAR    (IFMAP_PAR)
    ) u_mux_a (
        .feature_all(in_feature_q_a_all),
        .group_sel  (group_q),
        .valid      (mux_valid),
        .lanes      (in_feature_q_a_mux_all)
    );

    ifmap_group_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .INPUT_NUM_MEM(INPUT_NUM_MEM),
        .IFMAP_PAR    (IFMAP_PAR)
    ) u_mux_b (
        .feature_all(in_feature_q_b_all),
        .group_sel  (group_q),
        .valid      (mux_valid),
        .lanes      (in_feature_q_b_mux_all)
    );

endmodule
